// File: rtl/sha256_pkg.sv
// SHA-256 shared package: FSM state encodings and round constants used by
// the schedule, the compressor and the controller.
// Latency: n/a (definitions only). Backpressure: n/a.
package sha256_pkg;

  localparam int WORD_W  = 32;
  localparam int ROUNDS  = 64;
  localparam int WINDOW  = 16;

  // Round index boundaries of the schedule
  localparam logic [6:0] LAST_ROUND      = 7'd63;
  localparam logic [6:0] FIRST_EXP_ROUND = 7'd16;

  // Shared FSM_state bus encoding
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ROUND0to15  = 2'd1,
    ROUND16to63 = 2'd2,
    ROUND64     = 2'd3
  } fsm_state_e;

endpackage

// File: rtl/sha256_message_schedule_if.sv
// Message-schedule bus: block-start request in, W[t]/round/state out.
// Latency: n/a (wires only). Backpressure: none; the consumer is lock-stepped.
// Signals: start_in, block_in[511:0] -> schedule; message_out, round_out,
//          FSM_state_out, busy_out -> compressor/controller.
interface sha256_message_schedule_if;
  import sha256_pkg::*;

  logic                    start_in;
  logic [16*WORD_W-1:0]    block_in;
  logic [WORD_W-1:0]       message_out;
  logic [6:0]              round_out;
  logic [1:0]              FSM_state_out;
  logic                    busy_out;

  // master: the schedule generator (producer of message/round/state)
  modport master (
    input  start_in, block_in,
    output message_out, round_out, FSM_state_out, busy_out
  );

  // slave: the requester/consumer side
  modport slave (
    output start_in, block_in,
    input  message_out, round_out, FSM_state_out, busy_out
  );

endinterface

// File: rtl/sha256_message_schedule_sig.sv
// SHA-256 small sigma: sel_i=0 -> s0 (ROTR7^ROTR18^SHR3), sel_i=1 -> s1 (ROTR17^ROTR19^SHR10).
// Latency: combinational. Backpressure: none.
// Ports: sel_i (function select), x_i (operand), y_o (result).
module sha256_message_schedule_sig #(
  parameter int WORD_W = 32
) (
  input  logic              sel_i,
  input  logic [WORD_W-1:0] x_i,
  output logic [WORD_W-1:0] y_o
);
  import sha256_pkg::*;

  logic [WORD_W-1:0] r7;
  logic [WORD_W-1:0] r17;
  logic [WORD_W-1:0] r18;
  logic [WORD_W-1:0] r19;

  assign r7  = (x_i >> 7)  | (x_i << (WORD_W - 7));
  assign r17 = (x_i >> 17) | (x_i << (WORD_W - 17));
  assign r18 = (x_i >> 18) | (x_i << (WORD_W - 18));
  assign r19 = (x_i >> 19) | (x_i << (WORD_W - 19));

  assign y_o = sel_i ? (r17 ^ r19 ^ (x_i >> 10))
                     : (r7  ^ r18 ^ (x_i >> 3));

endmodule

// File: rtl/sha256_message_schedule.sv
// SHA-256 message schedule: loads a 512-bit block, emits W0..W63 one per clock.
// Latency: W0 one cycle after start accept; 66 cycles per block incl. finalise/idle.
// Backpressure: none; start_in is ignored while busy, consumer is lock-stepped.
// Ports: CLK, RST (async, active high), bus (master modport: start_in, block_in,
//        message_out, round_out, FSM_state_out, busy_out).
module sha256_message_schedule #(
  parameter int WORD_W = sha256_pkg::WORD_W,
  parameter int ROUNDS = sha256_pkg::ROUNDS
) (
  input  logic                        CLK,
  input  logic                        RST,
  sha256_message_schedule_if.master   bus
);
  import sha256_pkg::*;

  localparam logic [6:0] LAST_RND  = 7'(ROUNDS - 1);
  localparam logic [6:0] LAST_LOAD = FIRST_EXP_ROUND - 7'd1;

  fsm_state_e        state_q, state_d;
  logic [6:0]        round_q, round_d;
  logic              busy_q,  busy_d;
  logic              load;
  logic              shift;

  logic [WORD_W-1:0] w_q [WINDOW];
  logic [WORD_W-1:0] msg;
  logic [WORD_W-1:0] sig0;
  logic [WORD_W-1:0] sig1;

  // Expansion operands: s0 of w[1] (W[t-15]), s1 of w[14] (W[t-2])
  sha256_message_schedule_sig #(.WORD_W(WORD_W)) u_sig0 (
    .sel_i (1'b0),
    .x_i   (w_q[1]),
    .y_o   (sig0)
  );

  sha256_message_schedule_sig #(.WORD_W(WORD_W)) u_sig1 (
    .sel_i (1'b1),
    .x_i   (w_q[14]),
    .y_o   (sig1)
  );

  // Word presented to the compressor this cycle; no register stage so it
  // stays aligned with round_out.
  always_comb begin
    msg = '0;
    case (state_q)
      ROUND0to15:  msg = w_q[0];
      ROUND16to63: msg = sig1 + w_q[9] + sig0 + w_q[0];
      default:     msg = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_in) begin
          state_d = ROUND0to15;
          round_d = '0;
          load    = 1'b1;
        end
      end
      ROUND0to15: begin
        shift   = 1'b1;
        round_d = round_q + 7'd1;
        if (round_q == LAST_LOAD) state_d = ROUND16to63;
      end
      ROUND16to63: begin
        shift = 1'b1;
        if (round_q == LAST_RND) begin
          state_d = ROUND64;
          round_d = '0;
        end else begin
          round_d = round_q + 7'd1;
        end
      end
      ROUND64: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        round_d = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      round_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      busy_q  <= busy_d;
    end
  end

  // Window: w_q[0] is the oldest word; each round shifts down and appends
  // the word just emitted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < WINDOW; i++) w_q[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < WINDOW; i++)
        w_q[i] <= bus.block_in[(WINDOW*WORD_W-1) - WORD_W*i -: WORD_W];
    end else if (shift) begin
      for (int i = 0; i < WINDOW-1; i++) w_q[i] <= w_q[i+1];
      w_q[WINDOW-1] <= msg;
    end
  end

  assign bus.message_out   = msg;
  assign bus.round_out     = round_q;
  assign bus.FSM_state_out = state_q;
  assign bus.busy_out      = busy_q;

endmodule

// File: tb/tb_sha256_message_schedule.sv
// Bench for sha256_message_schedule: scoreboard of expected (state, round, W)
// per busy cycle, popped and compared by an independent monitor.
// Drives directed blocks ("abc", all-ones, patterns) plus reset/start corner cases.
module tb_sha256_message_schedule;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  sha256_message_schedule_if bus();

  sha256_message_schedule dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct packed {
    logic [1:0]  st;
    logic [6:0]  rnd;
    logic [31:0] msg;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  bit          mon_en = 1'b0;
  int          cyc = 0;
  logic [31:0] mw [64];

  always @(posedge CLK) cyc++;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Reference schedule: classic W[t] array form
  task automatic model(input logic [511:0] blk);
    for (int t = 0; t < 16; t++) mw[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      mw[t] = ssig1(mw[t-2]) + mw[t-7] + ssig0(mw[t-15]) + mw[t-16];
  endtask

  task automatic push_mw();
    exp_t e;
    for (int t = 0; t < 64; t++) begin
      e.st  = (t < 16) ? 2'd1 : 2'd2;
      e.rnd = 7'(t);
      e.msg = mw[t];
      q.push_back(e);
    end
    e.st = 2'd3; e.rnd = 7'd0; e.msg = 32'd0;
    q.push_back(e);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s_timeout: state=%0d round=%0d busy=%b, required event did not occur",
             name, bus.FSM_state_out, bus.round_out, bus.busy_out);
  endtask

  // Monitor: one expected entry per busy cycle; idle cycles must read all zero
  always @(negedge CLK) begin
    exp_t e;
    if (mon_en && !RST) begin
      if (bus.busy_out) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: state=%0d round=%0d msg=%h, required idle",
                   bus.FSM_state_out, bus.round_out, bus.message_out);
        end else begin
          e = q.pop_front();
          check($sformatf("sched_r%0d", e.rnd),
                {bus.FSM_state_out, bus.round_out, bus.message_out}, e);
        end
      end else begin
        check("idle_outputs", {bus.FSM_state_out, bus.round_out, bus.message_out}, 64'd0);
      end
    end
  end

  task automatic start_block(input logic [511:0] blk);
    @(negedge CLK);
    bus.start_in = 1'b1;
    bus.block_in = blk;
    @(posedge CLK);
    #1 bus.start_in = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy_out !== 1'b0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 200) timeout(name);
    @(negedge CLK);
  endtask

  task automatic wait_state(input string name, input logic [1:0] st, input logic [6:0] r);
    int n;
    n = 0;
    while (!(bus.FSM_state_out === st && bus.round_out === r) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 200) timeout(name);
  endtask

  logic [511:0] blk;
  logic [511:0] blk_b;
  int           c0, c1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_in = 1'b0;
    bus.block_in = '0;

    // Reset values
    repeat (3) @(posedge CLK);
    #1;
    check("rst_message", bus.message_out, 0);
    check("rst_round",   bus.round_out, 0);
    check("rst_state",   bus.FSM_state_out, 0);
    check("rst_busy",    bus.busy_out, 0);
    @(negedge CLK);
    RST = 1'b0;
    mon_en = 1'b1;

    // "abc" block with hand-computed expansion words
    blk = {32'h61626380, 448'h0, 32'h00000018};
    model(blk);
    mw[0]  = 32'h61626380;
    mw[15] = 32'h00000018;
    mw[16] = 32'h61626380;
    mw[17] = 32'h000F0000;
    mw[18] = 32'h7DA86405;
    mw[19] = 32'h600003C6;
    push_mw();
    start_block(blk);
    wait_idle("abc");

    // All-ones: carry/wraparound stress
    blk = {512{1'b1}};
    model(blk); push_mw();
    start_block(blk);
    wait_idle("ones");

    // Structured patterns
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 16; j++)
        blk[32*j +: 32] = (k == 0) ? 32'(j * 32'h01010101) :
                          (k == 1) ? ((j % 2 == 0) ? 32'hAAAA5555 : 32'h80000001) :
                                     (32'h1 << j);
      model(blk); push_mw();
      start_block(blk);
      wait_idle("pattern");
    end

    // A few random blocks
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 16; j++) blk[32*j +: 32] = $urandom;
      model(blk); push_mw();
      start_block(blk);
      wait_idle("random");
    end

    // start_in pulsed at round 30 must not disturb the running block
    for (int j = 0; j < 16; j++) blk[32*j +: 32] = 32'hC0DE0000 + 32'(j);
    blk_b = {512{1'b1}};
    model(blk); push_mw();
    start_block(blk);
    wait_state("pulse30", 2'd2, 7'd30);
    bus.start_in = 1'b1;
    bus.block_in = blk_b;
    @(negedge CLK);
    bus.start_in = 1'b0;
    wait_idle("pulse");

    // start_in held high: next block accepted exactly 66 cycles later
    for (int j = 0; j < 16; j++) blk[32*j +: 32] = 32'h12345678 ^ 32'(j << 4);
    for (int j = 0; j < 16; j++) blk_b[32*j +: 32] = 32'hFEDC0000 | 32'(j * 3);
    model(blk);   push_mw();
    model(blk_b); push_mw();
    @(negedge CLK);
    bus.start_in = 1'b1;
    bus.block_in = blk;
    @(posedge CLK);
    #1;
    c0 = cyc;
    bus.block_in = blk_b;
    @(negedge CLK);
    wait_state("hold_fin", 2'd3, 7'd0);
    wait_state("hold_next", 2'd1, 7'd0);
    c1 = cyc;
    bus.start_in = 1'b0;
    check("hold_period", 64'(c1 - c0), 64'd66);
    wait_idle("hold");

    // Asynchronous reset mid-block
    mon_en = 1'b0;
    blk = {512{1'b1}};
    start_block(blk);
    repeat (20) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    check("midrst_message", bus.message_out, 0);
    check("midrst_round",   bus.round_out, 0);
    check("midrst_state",   bus.FSM_state_out, 0);
    check("midrst_busy",    bus.busy_out, 0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    check("postrst_state", bus.FSM_state_out, 0);
    check("postrst_busy",  bus.busy_out, 0);
    mon_en = 1'b1;

    // Window was cleared by reset, so a fresh block must schedule cleanly
    blk = {32'h61626380, 448'h0, 32'h00000018};
    model(blk); push_mw();
    start_block(blk);
    wait_idle("after_reset");

    repeat (3) @(negedge CLK);
    check("queue_empty", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
